cu_read_command_arbiter: RTL and testbench

Round-robin arbiter that shares the single read-command channel of a PageRank CSR pull compute unit between its command-generating control units: vertex control, edge-data read, edge-data write and prefetch. Grants one request per cycle into a single-entry output register, aligns the address to the 128-byte cacheline, and limits outstanding reads with a credit counter sized to the job buffer depth. Sits between the per-CU control blocks and the CU-level command buffer; tracks completions so a graceful drain can be signalled.

---
 rtl/cu_read_command_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cu_read_command_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_read_command_arbiter.sv
// Round-robin read-command arbiter for a PageRank CSR pull compute unit.
// Grants one request per cycle into a single-entry output register, aligns to 128 B, and limits outstanding reads with credits.
module cu_read_command_arbiter #(
    parameter int NUM_REQUESTORS = 4,
    parameter int CREDITS        = 64,
    parameter int CREDIT_BITS    = $clog2(CREDITS) + 1
) (
    input  logic                          clock,
    input  logic                          rstn,
    input  logic                          enabled_in,
    input  logic [NUM_REQUESTORS-1:0]     req_valid_in,
    input  logic [NUM_REQUESTORS*64-1:0]  req_address_in,
    input  logic [NUM_REQUESTORS*8-1:0]   req_size_in,
    input  logic [NUM_REQUESTORS*8-1:0]   req_cu_id_in,
    output logic [NUM_REQUESTORS-1:0]     req_ready_out,
    output logic                          cmd_valid_out,
    output logic [63:0]                   cmd_address_out,
    output logic [7:0]                    cmd_size_out,
    output logic [7:0]                    cmd_cu_id_out,
    input  logic                          cmd_ready_in,
    input  logic                          rsp_done_in,
    output logic [CREDIT_BITS-1:0]        credits_out,
    output logic                          drain_done_out,
    output logic                          credit_error_out,
    output logic [1:0]                    state_out
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Once cmd_valid_out is high, all cmd_* fields hold until cmd_ready_in is seen.
    localparam int IDX_W = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1;
    localparam logic [CREDIT_BITS-1:0] CREDITS_FULL = CREDIT_BITS'(CREDITS);
    localparam logic [63:0] LINE_MASK = ~64'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CREDIT_BITS-1:0] credits_q, credits_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [63:0]            cmd_address_q, cmd_address_d;
    logic [7:0]             cmd_size_q, cmd_size_d;
    logic [7:0]             cmd_cu_id_q, cmd_cu_id_d;
    logic                   drain_done_q, drain_done_d;
    logic                   credit_error_q, credit_error_d;

    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       cand;
    logic                   grant_ok;
    logic                   grant;
    logic [63:0]            sel_address;
    logic [7:0]             sel_size;
    logic [7:0]             sel_cu_id;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQUESTORS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQUESTORS);
            if (!sel_found && req_valid_in[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign grant_ok    = (state_q == RUN) && enabled_in && (credits_q != '0) &&
                         (!cmd_valid_q || cmd_ready_in);
    assign grant       = grant_ok && sel_found;
    assign sel_address = req_address_in[int'(sel_idx)*64 +: 64];
    assign sel_size    = req_size_in[int'(sel_idx)*8 +: 8];
    assign sel_cu_id   = req_cu_id_in[int'(sel_idx)*8 +: 8];

    always_comb begin
        req_ready_out = '0;
        if (grant) begin
            req_ready_out[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        last_d        = last_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_address_d = cmd_address_q;
        cmd_size_d    = cmd_size_q;
        cmd_cu_id_d   = cmd_cu_id_q;
        if (grant) begin
            last_d        = sel_idx;
            cmd_valid_d   = 1'b1;
            cmd_address_d = sel_address & LINE_MASK;
            cmd_size_d    = sel_size;
            cmd_cu_id_d   = sel_cu_id;
        end else if (cmd_ready_in) begin
            cmd_valid_d   = 1'b0;
            cmd_address_d = '0;
            cmd_size_d    = '0;
            cmd_cu_id_d   = '0;
        end
    end

    // A grant and a completion in the same cycle cancel out.
    always_comb begin
        credits_d      = credits_q;
        credit_error_d = credit_error_q;
        if (grant && !rsp_done_in) begin
            credits_d = credits_q - CREDIT_BITS'(1);
        end else if (!grant && rsp_done_in) begin
            if (credits_q == CREDITS_FULL) begin
                credit_error_d = 1'b1;
            end else begin
                credits_d = credits_q + CREDIT_BITS'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enabled_in) state_d = RUN;
            end
            RUN: begin
                if (!enabled_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (enabled_in) begin
                    state_d = RUN;
                end else if (!cmd_valid_q && credits_q == CREDITS_FULL) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            last_q         <= IDX_W'(NUM_REQUESTORS - 1);
            credits_q      <= CREDITS_FULL;
            cmd_valid_q    <= 1'b0;
            cmd_address_q  <= '0;
            cmd_size_q     <= '0;
            cmd_cu_id_q    <= '0;
            drain_done_q   <= 1'b0;
            credit_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            credits_q      <= credits_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_address_q  <= cmd_address_d;
            cmd_size_q     <= cmd_size_d;
            cmd_cu_id_q    <= cmd_cu_id_d;
            drain_done_q   <= drain_done_d;
            credit_error_q <= credit_error_d;
        end
    end

    assign cmd_valid_out    = cmd_valid_q;
    assign cmd_address_out  = cmd_address_q;
    assign cmd_size_out     = cmd_size_q;
    assign cmd_cu_id_out    = cmd_cu_id_q;
    assign credits_out      = credits_q;
    assign drain_done_out   = drain_done_q;
    assign credit_error_out = credit_error_q;
    assign state_out        = state_q;

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Directed bench for cu_read_command_arbiter: fairness, alignment, backpressure, credits, drain, error and reset.
module tb_cu_read_command_arbiter;

    localparam int N  = 4;
    localparam int CB = 7;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic          clock;
    logic          rstn;
    logic          enabled_in;
    logic [N-1:0]  req_valid_in;
    logic [N*64-1:0] req_address_in;
    logic [N*8-1:0]  req_size_in;
    logic [N*8-1:0]  req_cu_id_in;
    logic [N-1:0]  req_ready_out;
    logic          cmd_valid_out;
    logic [63:0]   cmd_address_out;
    logic [7:0]    cmd_size_out;
    logic [7:0]    cmd_cu_id_out;
    logic          cmd_ready_in;
    logic          rsp_done_in;
    logic [CB-1:0] credits_out;
    logic          drain_done_out;
    logic          credit_error_out;
    logic [1:0]    state_out;

    int tests;
    int fails;

    cu_read_command_arbiter #(
        .NUM_REQUESTORS(N),
        .CREDITS(64),
        .CREDIT_BITS(CB)
    ) dut (
        .clock(clock),
        .rstn(rstn),
        .enabled_in(enabled_in),
        .req_valid_in(req_valid_in),
        .req_address_in(req_address_in),
        .req_size_in(req_size_in),
        .req_cu_id_in(req_cu_id_in),
        .req_ready_out(req_ready_out),
        .cmd_valid_out(cmd_valid_out),
        .cmd_address_out(cmd_address_out),
        .cmd_size_out(cmd_size_out),
        .cmd_cu_id_out(cmd_cu_id_out),
        .cmd_ready_in(cmd_ready_in),
        .rsp_done_in(rsp_done_in),
        .credits_out(credits_out),
        .drain_done_out(drain_done_out),
        .credit_error_out(credit_error_out),
        .state_out(state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] addr, input logic [7:0] size,
                           input logic [7:0] id);
        req_address_in[i*64 +: 64] = addr;
        req_size_in[i*8 +: 8]      = size;
        req_cu_id_in[i*8 +: 8]     = id;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  64'(req_ready_out), 64'h0);
        check({tag, "_valid"},  64'(cmd_valid_out), 64'h0);
        check({tag, "_addr"},   cmd_address_out, 64'h0);
        check({tag, "_size"},   64'(cmd_size_out), 64'h0);
        check({tag, "_id"},     64'(cmd_cu_id_out), 64'h0);
        check({tag, "_credits"}, 64'(credits_out), 64'd64);
        check({tag, "_drain"},  64'(drain_done_out), 64'h0);
        check({tag, "_err"},    64'(credit_error_out), 64'h0);
        check({tag, "_state"},  64'(state_out), 64'(S_IDLE));
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rstn           = 1'b0;
        enabled_in     = 1'b0;
        req_valid_in   = '0;
        req_address_in = '0;
        req_size_in    = '0;
        req_cu_id_in   = '0;
        cmd_ready_in   = 1'b0;
        rsp_done_in    = 1'b0;

        #12;
        check_reset_values("reset");
        @(negedge clock);
        rstn = 1'b1;

        // Fairness: all requesters valid, downstream always ready.
        for (int i = 0; i < N; i++) set_req(i, 64'(i) * 64'h100 + 64'h5, 8'd64, 8'h10 + 8'(i));
        enabled_in   = 1'b1;
        cmd_ready_in = 1'b1;
        req_valid_in = 4'b1111;
        #1;
        check("idle_no_grant", 64'(req_ready_out), 64'h0);
        step();
        check("run_state", 64'(state_out), 64'(S_RUN));
        check("first_grant_req0", 64'(req_ready_out), 64'h1);
        for (int g = 1; g <= 7; g++) begin
            step();
            check("rr_valid", 64'(cmd_valid_out), 64'h1);
            check("rr_id", 64'(cmd_cu_id_out), 64'h10 + 64'((g - 1) % 4));
            check("rr_addr", cmd_address_out, 64'((g - 1) % 4) * 64'h100);
            check("rr_size", 64'(cmd_size_out), 64'd64);
            check("rr_ready", 64'(req_ready_out), 64'h1 << (g % 4));
            check("rr_credits", 64'(credits_out), 64'(64 - g));
        end
        req_valid_in = 4'b0000;
        step();
        check("idle_clear_valid", 64'(cmd_valid_out), 64'h0);
        check("idle_credits", 64'(credits_out), 64'd57);

        // Alignment: requester 2, address 0x1000_007F, size 128.
        set_req(2, 64'h1000_007F, 8'd128, 8'h22);
        req_valid_in = 4'b0100;
        #1;
        check("align_ready", 64'(req_ready_out), 64'h4);
        step();
        check("align_valid", 64'(cmd_valid_out), 64'h1);
        check("align_addr", cmd_address_out, 64'h1000_0000);
        check("align_size", 64'(cmd_size_out), 64'd128);
        check("align_id", 64'(cmd_cu_id_out), 64'h22);
        check("align_credits", 64'(credits_out), 64'd56);

        // Backpressure: held command stays stable, no grants for 5 cycles.
        set_req(2, 64'h205, 8'd64, 8'h12);
        cmd_ready_in = 1'b0;
        req_valid_in = 4'b1111;
        #1;
        check("bp_no_grant", 64'(req_ready_out), 64'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_ready", 64'(req_ready_out), 64'h0);
            check("bp_valid", 64'(cmd_valid_out), 64'h1);
            check("bp_addr", cmd_address_out, 64'h1000_0000);
            check("bp_size", 64'(cmd_size_out), 64'd128);
            check("bp_id", 64'(cmd_cu_id_out), 64'h22);
            check("bp_credits", 64'(credits_out), 64'd56);
        end
        cmd_ready_in = 1'b1;
        #1;
        check("bp_resume_ready", 64'(req_ready_out), 64'h8);
        step();
        check("bp_resume_id", 64'(cmd_cu_id_out), 64'h13);
        check("bp_resume_credits", 64'(credits_out), 64'd55);
        req_valid_in = 4'b0000;
        step();
        check("bp_clear", 64'(cmd_valid_out), 64'h0);

        // Credit exhaustion with requester 0 only.
        req_valid_in = 4'b0001;
        #1;
        check("ex_start_ready", 64'(req_ready_out), 64'h1);
        for (int k = 1; k <= 55; k++) begin
            step();
            check("ex_credits", 64'(credits_out), 64'(55 - k));
        end
        check("ex_zero_no_grant", 64'(req_ready_out), 64'h0);
        rsp_done_in = 1'b1;
        #1;
        check("ex_zero_rsp_no_grant", 64'(req_ready_out), 64'h0);
        step();
        check("ex_one_credit", 64'(credits_out), 64'd1);
        rsp_done_in = 1'b0;
        #1;
        check("ex_one_grant", 64'(req_ready_out), 64'h1);
        step();
        check("ex_back_zero", 64'(credits_out), 64'd0);
        check("ex_again_no_grant", 64'(req_ready_out), 64'h0);
        step();
        check("ex_still_zero", 64'(credits_out), 64'd0);
        rsp_done_in = 1'b1;
        step();
        check("sim_pre_credit", 64'(credits_out), 64'd1);
        check("sim_ready", 64'(req_ready_out), 64'h1);
        step();
        check("sim_credit_const", 64'(credits_out), 64'd1);
        check("sim_valid", 64'(cmd_valid_out), 64'h1);
        rsp_done_in  = 1'b0;
        req_valid_in = 4'b0000;
        step();
        check("sim_idle_credit", 64'(credits_out), 64'd1);

        // Drain: bring to 61 credits with one command held downstream.
        rsp_done_in = 1'b1;
        for (int k = 0; k < 61; k++) step();
        rsp_done_in = 1'b0;
        check("drain_prep_credits", 64'(credits_out), 64'd62);
        cmd_ready_in = 1'b0;
        req_valid_in = 4'b0001;
        #1;
        check("drain_prep_ready", 64'(req_ready_out), 64'h1);
        step();
        check("drain_held_valid", 64'(cmd_valid_out), 64'h1);
        check("drain_held_credits", 64'(credits_out), 64'd61);
        enabled_in = 1'b0;
        #1;
        check("drain_disabled_ready", 64'(req_ready_out), 64'h0);
        step();
        check("drain_state", 64'(state_out), 64'(S_DRAIN));
        check("drain_no_grant", 64'(req_ready_out), 64'h0);
        cmd_ready_in = 1'b1;
        rsp_done_in  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("drain_credits", 64'(credits_out), 64'(61 + k));
            check("drain_pulse_low", 64'(drain_done_out), 64'h0);
            check("drain_ready_low", 64'(req_ready_out), 64'h0);
            check("drain_state_hold", 64'(state_out), 64'(S_DRAIN));
        end
        check("drain_cmd_gone", 64'(cmd_valid_out), 64'h0);
        rsp_done_in = 1'b0;
        step();
        check("drain_done_pulse", 64'(drain_done_out), 64'h1);
        check("drain_to_idle", 64'(state_out), 64'(S_IDLE));
        step();
        check("drain_done_once", 64'(drain_done_out), 64'h0);

        // Credit error: completion while the counter is full.
        req_valid_in = 4'b0000;
        rsp_done_in  = 1'b1;
        step();
        check("err_set", 64'(credit_error_out), 64'h1);
        check("err_credits", 64'(credits_out), 64'd64);
        rsp_done_in = 1'b0;
        step();
        check("err_sticky", 64'(credit_error_out), 64'h1);

        // Asynchronous reset in the middle of a burst.
        enabled_in   = 1'b1;
        req_valid_in = 4'b1111;
        step();
        check("burst_ready", 64'(req_ready_out), 64'h2);
        step();
        check("burst_id1", 64'(cmd_cu_id_out), 64'h11);
        step();
        check("burst_id2", 64'(cmd_cu_id_out), 64'h12);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        #2;
        rstn = 1'b1;
        step();
        check("post_reset_ready", 64'(req_ready_out), 64'h1);
        step();
        check("post_reset_id", 64'(cmd_cu_id_out), 64'h10);
        check("post_reset_credits", 64'(credits_out), 64'd63);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
